// File: rtl/pixel_compositor.sv
// Display compositor: VGA coordinates to framebuffer reads, cursor/preview layering, self-clear.
// Optional brush-outline cursor hit enabled by defining CURSOR_OUTLINE_EN.
module pixel_compositor #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_OFFSET = 145,
    parameter int V_OFFSET = 36,
    parameter int CBITS    = 3,
    parameter int OUT_BITS = 8,
    parameter int RD_LAT   = 1,
    parameter logic [3*CBITS-1:0]    CLEAR_COLOR  = '1,
    parameter logic [3*OUT_BITS-1:0] CURSOR_COLOR = {{OUT_BITS{1'b1}}, {(2*OUT_BITS){1'b0}}},
    localparam int ADDR_W = $clog2(H_ACTIVE * V_ACTIVE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  ativo,
    input  logic [10:0]           vga_x,
    input  logic [10:0]           vga_y,
    input  logic [10:0]           cursor_x,
    input  logic [10:0]           cursor_y,
    input  logic [5:0]            radius,
    input  logic                  preview,
    input  logic [3*CBITS-1:0]    color_in,
    output logic                  mem_re,
    output logic [ADDR_W-1:0]     mem_rd_addr,
    input  logic [3*CBITS-1:0]    mem_rd_data,
    output logic                  clr_we,
    output logic [ADDR_W-1:0]     clr_addr,
    output logic [3*CBITS-1:0]    clr_data,
    output logic                  busy,
    output logic [OUT_BITS-1:0]   vga_r,
    output logic [OUT_BITS-1:0]   vga_g,
    output logic [OUT_BITS-1:0]   vga_b
);

    // state | meaning
    // CLEAR | writing CLEAR_COLOR to every framebuffer word, display blanked
    // RUN   | normal compositing from framebuffer reads

    localparam int PW   = 3 * CBITS;
    localparam int OW   = 3 * OUT_BITS;
    localparam int NPIX = H_ACTIVE * V_ACTIVE;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic signed [11:0] H_OFF_S = 12'(H_OFFSET);
    localparam logic signed [11:0] V_OFF_S = 12'(V_OFFSET);
    localparam logic signed [11:0] H_ACT_S = 12'(H_ACTIVE);
    localparam logic signed [11:0] V_ACT_S = 12'(V_ACTIVE);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t state, state_next;

    function automatic logic [OW-1:0] expand(input logic [PW-1:0] p);
        logic [OW-1:0] o;
        o = '0;
        for (int c = 0; c < 3; c++) begin
            o[c*OUT_BITS +: OUT_BITS] = OUT_BITS'(p[c*CBITS +: CBITS]) << (OUT_BITS - CBITS);
        end
        return o;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        clr_we     = 1'b0;
        case (state)
            CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (clr_addr == LAST_ADDR) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (clear) begin
                    state_next = CLEAR;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    // Address rests at zero in RUN so a new clear always starts from the top.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_addr <= '0;
        end else if (state == CLEAR) begin
            clr_addr <= (clr_addr == LAST_ADDR) ? '0 : clr_addr + ADDR_W'(1);
        end else begin
            clr_addr <= '0;
        end
    end

    assign clr_data = CLEAR_COLOR;

    logic signed [11:0] fx, fy, dx, dy;
    logic [11:0]        adx, ady, rad12;
    logic               vis_c, hit_c, cross_c;
    logic [ADDR_W-1:0]  rd_addr_c;

    assign fx    = $signed({1'b0, vga_x}) - H_OFF_S;
    assign fy    = $signed({1'b0, vga_y}) - V_OFF_S;
    assign dx    = fx - $signed({1'b0, cursor_x});
    assign dy    = fy - $signed({1'b0, cursor_y});
    assign adx   = dx[11] ? -dx : dx;
    assign ady   = dy[11] ? -dy : dy;
    assign rad12 = {6'b0, radius};

    assign vis_c = ativo && !fx[11] && (fx < H_ACT_S) && !fy[11] && (fy < V_ACT_S);
    assign rd_addr_c = vis_c
        ? ADDR_W'($unsigned(fy)) * ADDR_W'(H_ACTIVE) + ADDR_W'($unsigned(fx))
        : '0;

    assign cross_c = ((dx == '0) && (ady <= rad12)) || ((dy == '0) && (adx <= rad12));

`ifdef CURSOR_OUTLINE_EN
    logic [23:0] sq_x, sq_y;
    logic [24:0] dist2;
    logic [11:0] r_sq, rm1_sq;
    logic [5:0]  rm1;
    logic        ring_c;

    assign sq_x   = {12'b0, adx} * {12'b0, adx};
    assign sq_y   = {12'b0, ady} * {12'b0, ady};
    assign dist2  = {1'b0, sq_x} + {1'b0, sq_y};
    assign rm1    = radius - 6'd1;
    assign r_sq   = rad12 * rad12;
    assign rm1_sq = {6'b0, rm1} * {6'b0, rm1};
    // radius 0 would make (radius-1) wrap, so the ring is suppressed outright.
    assign ring_c = (radius != 6'd0) && (dist2 > 25'(rm1_sq)) && (dist2 <= 25'(r_sq));
    assign hit_c  = cross_c || ring_c;
`else
    assign hit_c  = cross_c;
`endif

    // Anything sampled while clearing, or on the edge into a clear, enters as a bubble.
    logic run_ok;
    assign run_ok = (state == RUN) && (state_next == RUN);

    logic          vis1, hit1, prev1;
    logic [PW-1:0] col1;

    always_ff @(posedge clk) begin
        if (reset || !run_ok) begin
            mem_re      <= 1'b0;
            mem_rd_addr <= '0;
            vis1        <= 1'b0;
            hit1        <= 1'b0;
            prev1       <= 1'b0;
            col1        <= '0;
        end else begin
            mem_re      <= vis_c;
            mem_rd_addr <= rd_addr_c;
            vis1        <= vis_c;
            hit1        <= hit_c;
            prev1       <= preview;
            col1        <= color_in;
        end
    end

    logic [RD_LAT-1:0] vis_d, hit_d, prev_d;
    logic [PW-1:0]     col_d [RD_LAT];

    always_ff @(posedge clk) begin
        if (reset || !run_ok) begin
            vis_d  <= '0;
            hit_d  <= '0;
            prev_d <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                col_d[i] <= '0;
            end
        end else begin
            vis_d[0]  <= vis1;
            hit_d[0]  <= hit1;
            prev_d[0] <= prev1;
            col_d[0]  <= col1;
            for (int i = 1; i < RD_LAT; i++) begin
                vis_d[i]  <= vis_d[i-1];
                hit_d[i]  <= hit_d[i-1];
                prev_d[i] <= prev_d[i-1];
                col_d[i]  <= col_d[i-1];
            end
        end
    end

    logic [OW-1:0] pix_c, rgb_q;

    always_comb begin
        pix_c = '0;
        if (vis_d[RD_LAT-1]) begin
            if (prev_d[RD_LAT-1]) begin
                pix_c = expand(col_d[RD_LAT-1]);
            end else if (hit_d[RD_LAT-1]) begin
                pix_c = CURSOR_COLOR;
            end else begin
                pix_c = expand(mem_rd_data);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || state_next == CLEAR) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= pix_c;
        end
    end

    assign vga_r = rgb_q[2*OUT_BITS +: OUT_BITS];
    assign vga_g = rgb_q[OUT_BITS +: OUT_BITS];
    assign vga_b = rgb_q[0 +: OUT_BITS];

endmodule

// File: doc/pixel_compositor.md
# pixel_compositor

Parametrised display compositor between the VGA timing generator, the two-port framebuffer RAM and the cursor/colour controls. Converts raw VGA coordinates to a framebuffer read address, aligns the returned pixel with overlay flags through a latency-matched pipeline, and layers the colour preview, the cursor and the framebuffer into registered RGB. Clears the framebuffer itself on reset or on request, replacing the RAM's private init handshake. Adds resolution, colour depth, read-latency and cursor-colour generics, plus signed cursor arithmetic with no wrap-around at screen edges.

## Interface
- H_ACTIVE, 640: visible pixels per line
- V_ACTIVE, 480: visible lines
- H_OFFSET, 145: VGA x of first visible pixel
- V_OFFSET, 36: VGA y of first visible line
- CBITS, 3: stored bits per channel; pixel word = 3*CBITS, order {R,G,B}
- OUT_BITS, 8: output bits per channel
- RD_LAT, 1: RAM read latency in cycles, 1..4
- CLEAR_COLOR, all ones: 3*CBITS word written by a clear
- CURSOR_COLOR, {max,0,0}: 3*OUT_BITS overlay colour (red)
- ADDR_W: derived, ceil(log2(H_ACTIVE*V_ACTIVE))
- Ports:
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-high
- clear  in  1  one-cycle pulse requesting a framebuffer clear
- ativo  in  1  VGA active-video flag
- vga_x, vga_y  in  11 each  raw VGA counters
- cursor_x, cursor_y  in  11 each  cursor position in framebuffer coordinates
- radius  in  6  brush radius
- preview  in  1  colour-preview mode
- color_in  in  3*CBITS  current brush colour
- mem_re  out  1  read enable
- mem_rd_addr  out  ADDR_W  read address
- mem_rd_data  in  3*CBITS  read data
- clr_we  out  1  clear write enable
- clr_addr  out  ADDR_W  clear write address
- clr_data  out  3*CBITS  clear write data (CLEAR_COLOR)
- busy  out  1  high while clearing
- vga_r, vga_g, vga_b  out  OUT_BITS each  registered colour

## Operation
- FSM states: CLEAR, RUN. Reset enters CLEAR with clr_addr=0.
- CLEAR: clr_we=1, busy=1, one write per cycle at clr_addr 0..H_ACTIVE*V_ACTIVE-1. After the last address, go to RUN with clr_we=0 and busy=0. mem_re=0. RGB=0. preview is ignored. A clear pulse in CLEAR is ignored.
- RUN: a clear pulse enters CLEAR at clr_addr=0 on the next cycle.
- Coordinates: fx=vga_x-H_OFFSET, fy=vga_y-V_OFFSET, in 12-bit signed.
- Visible when ativo and 0<=fx<H_ACTIVE and 0<=fy<V_ACTIVE. If not visible: mem_re=0, mem_rd_addr=0.
- Read address: addr=fy*H_ACTIVE+fx.
- Cursor hit: dx=fx-cursor_x, dy=fy-cursor_y, in 12-bit signed (no unsigned wrap). Hit when (dx==0 and |dy|<=radius) or (dy==0 and |dx|<=radius).
- Priority, highest first:
  - not visible → 0
  - preview → color_in
  - cursor hit → CURSOR_COLOR
  - otherwise → mem_rd_data
- Expansion from CBITS to OUT_BITS: channel << (OUT_BITS-CBITS), zero-filled.
- Reset in any state forces CLEAR and zeroes all pipeline flags and outputs.

## Timing
- Reset values:
  - mem_re=0, mem_rd_addr=0
  - clr_we=1 on the first cycle after reset; clr_addr=0
  - busy=1
  - vga_r/g/b=0
- Clear duration: exactly H_ACTIVE*V_ACTIVE cycles (307200 at defaults). The first RUN cycle follows the last write.
- Stage 1 registers mem_rd_addr, mem_re, visible, hit and preview.
- Flags and a registered copy of color_in are delayed RD_LAT cycles to align with mem_rd_data.
- Output register follows.
- Latency from vga_x/vga_y to RGB: RD_LAT+2 cycles (3 at defaults).
- Pipeline flags entering during CLEAR are forced invisible, so no stale pixel shows after CLEAR→RUN.

## Configuration
- CURSOR_OUTLINE_EN defined: cursor hit also includes the brush outline, (radius-1)^2 < dx^2+dy^2 <= radius^2, using 12-bit squares. With radius=0 the outline is empty.
- CURSOR_OUTLINE_EN undefined: crosshair only, no multipliers for the outline.

## Test plan
- Reset, then run 307200 cycles:
  - clr_we high with clr_addr stepping 0..307199
  - busy falls the cycle after addr 307199
  - RGB=0 throughout
- RUN, ativo=1, vga_x=145, vga_y=36, preview=0, no cursor hit:
  - mem_rd_addr=0 after 1 cycle
  - with mem_rd_data=9'b111000000, vga_r=224, g=0, b=0 at cycle 3
- Cursor (0,0), radius=20, vga_x=145, vga_y=40 → red 255,0,0.
- Same cursor, vga_x=144 (fx=-1, not visible) → 0,0,0; no wrap hit.
- preview=1, color_in=9'b001010011, cursor over pixel → 32,64,96.
- clear pulse mid-frame in RUN → busy=1 next cycle and clr_addr restarts at 0. reset asserted at clr_addr=1000 → clr_addr=0 next cycle.
